// File: rtl/vga_pkg.sv
// Shared VGA geometry, pixel layout and sprite configuration types for the
// pixel-generation blocks that sit upstream of the VGA timing block.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int LOOKAHEAD = 2;
  localparam int PIX_W     = 12;
  localparam int COL_W     = 10;
  localparam int ROW_W     = 9;

  // Pixel word is bbbb_gggg_rrrr
  localparam int CH_W  = 4;
  localparam int R_LSB = 0;
  localparam int G_LSB = 4;
  localparam int B_LSB = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic             en;
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
  } spr_cfg_t;

  function automatic pix_t make_pix(input logic [CH_W-1:0] b,
                                    input logic [CH_W-1:0] g,
                                    input logic [CH_W-1:0] r);
    pix_t p;
    p = '0;
    p[B_LSB +: CH_W] = b;
    p[G_LSB +: CH_W] = g;
    p[R_LSB +: CH_W] = r;
    return p;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Bounding-box test of one sprite against the lookahead position; the
// subtractions wrap so sprites partly left of or above the screen still clip.
module sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic [COL_W-1:0]         la_col,
  input  logic [ROW_W-1:0]         row,
  input  spr_cfg_t                 cfg,
  output logic                     hit,
  output logic [$clog2(SPR_W)-1:0] dx,
  output logic [$clog2(SPR_H)-1:0] dy
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [COL_W-1:0] dx_full;
  logic [ROW_W-1:0] dy_full;

  // Power-of-two sizes: "offset < size" is the same as "upper offset bits zero"
  always_comb begin
    dx_full = la_col - cfg.x;
    dy_full = row - cfg.y;
    hit     = cfg.en && (dx_full[COL_W-1:XW] == '0) && (dy_full[ROW_W-1:YW] == '0);
    dx      = dx_full[XW-1:0];
    dy      = dy_full[YW-1:0];
  end

endmodule

// File: rtl/sprite_compositor.sv
// Composites NSPR ROM-backed sprites over a flat background, two cycles ahead
// of the VGA address so the registered pixel lines up with col_addr.
module sprite_compositor
  import vga_pkg::*;
#(
  parameter int         NSPR     = 4,
  parameter int         SPR_W    = 32,
  parameter int         SPR_H    = 32,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter logic [11:0] TRANSP   = 12'hF0F,
  localparam int        IW       = $clog2(NSPR),
  localparam int        XW       = $clog2(SPR_W),
  localparam int        YW       = $clog2(SPR_H),
  localparam int        AW       = IW + YW + XW
) (
  input  logic             vga_clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_addr,
  input  logic [COL_W-1:0] col_addr,
  input  logic             vs,
  output logic [PIX_W-1:0] pixel,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [COL_W-1:0] cfg_x,
  input  logic [ROW_W-1:0] cfg_y,
  input  logic             cfg_en
);

  logic [COL_W-1:0] la_col;
  logic             act_c;
  logic             act_q;
  logic             hit_q;
  logic             vs_q;
  logic             commit;
  logic             cfg_wr;

  spr_cfg_t pend_cfg [NSPR];
  spr_cfg_t act_cfg  [NSPR];

  logic [NSPR-1:0] hits;
  logic [XW-1:0]   dx [NSPR];
  logic [YW-1:0]   dy [NSPR];

  logic          win_hit;
  logic [IW-1:0] win_idx;
  logic [XW-1:0] win_dx;
  logic [YW-1:0] win_dy;

  assign la_col = col_addr + COL_W'(LOOKAHEAD);
  assign act_c  = (la_col < COL_W'(H_ACTIVE)) && (row_addr < ROW_W'(V_ACTIVE));

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    sprite_hit #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
    ) u_hit (
      .la_col (la_col),
      .row    (row_addr),
      .cfg    (act_cfg[g]),
      .hit    (hits[g]),
      .dx     (dx[g]),
      .dy     (dy[g])
    );
  end

  // Scan from the top index down so the lowest hitting index is left standing
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hits[i]) begin
        win_hit = 1'b1;
        win_idx = IW'(i);
        win_dx  = dx[i];
        win_dy  = dy[i];
      end
    end
    rom_addr = win_hit ? {win_idx, win_dy, win_dx} : '0;
  end

  // The commit owns the banks for its one cycle, so writes are held off then
  assign commit    = vs_q && !vs;
  assign cfg_ready = !commit;
  assign cfg_wr    = cfg_valid && cfg_ready;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b1;
      for (int i = 0; i < NSPR; i++) begin
        pend_cfg[i] <= '0;
        act_cfg[i]  <= '0;
      end
    end else begin
      vs_q <= vs;
      if (cfg_wr) begin
        pend_cfg[cfg_idx] <= '{en: cfg_en, x: cfg_x, y: cfg_y};
      end
      if (commit) begin
        for (int i = 0; i < NSPR; i++) begin
          act_cfg[i] <= pend_cfg[i];
        end
      end
    end
  end

  // rom_data arrives alongside act_q/hit_q, one cycle after rom_addr
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      hit_q <= 1'b0;
      pixel <= '0;
    end else begin
      act_q <= act_c;
      hit_q <= win_hit;
      if (!act_q) begin
        pixel <= '0;
      end else if (hit_q && (rom_data != TRANSP)) begin
        pixel <= rom_data;
      end else begin
        pixel <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: drives row/col addresses line-segment
// by line-segment against a small sprite ROM and checks the registered pixel.
module tb_sprite_compositor;
  import vga_pkg::*;

  localparam logic [11:0] BG = 12'h0A5;
  localparam logic [11:0] TR = 12'hF0F;
  localparam logic [11:0] S0 = 12'h00F;
  localparam logic [11:0] S1 = 12'h0F0;
  localparam logic [11:0] S2 = 12'h333;

  logic        vga_clk;
  logic        rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        vs;
  logic [11:0] pixel;
  logic [11:0] rom_addr;
  logic [11:0] rom_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_x;
  logic [8:0]  cfg_y;
  logic        cfg_en;

  logic [11:0] rom_mem [4096];

  int errors = 0;
  int checks = 0;

  sprite_compositor #(
    .NSPR     (4),
    .SPR_W    (32),
    .SPR_H    (32),
    .BG_COLOR (BG),
    .TRANSP   (TR)
  ) dut (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .vs        (vs),
    .pixel     (pixel),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .cfg_en    (cfg_en)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // External synchronous sprite ROM
  always @(posedge vga_clk) rom_data <= rom_mem[rom_addr];

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Walk col_addr from c0-2 so the pipeline is primed; pixel shows column c
  // while col_addr == c
  task automatic check_span(input int row, input int c0, input int c1, input logic [11:0] exp);
    row_addr = 9'(row);
    for (int c = c0 - 2; c <= c1; c++) begin
      col_addr = 10'(c);
      if (c >= c0) check_output($sformatf("pix r%0d c%0d", row, c), pixel, exp);
      step();
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input logic en);
    int n;
    n = 0;
    while (!cfg_ready && n < 8) begin
      step();
      n++;
    end
    check_output("cfg_ready before write", {11'b0, cfg_ready}, 12'h001);
    cfg_valid = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_x     = 10'(x);
    cfg_y     = 9'(y);
    cfg_en    = en;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    vs = 1'b0;
    step();
    step();
    vs = 1'b1;
    step();
  endtask

  initial begin
    logic [11:0] a;
    rst       = 1'b1;
    vs        = 1'b1;
    cfg_valid = 1'b0;
    cfg_idx   = '0;
    cfg_x     = '0;
    cfg_y     = '0;
    cfg_en    = 1'b0;
    row_addr  = '0;
    col_addr  = '0;
    for (int i = 0; i < 4096; i++) begin
      a = 12'(i);
      case (a[11:10])
        2'd0:    rom_mem[i] = S0;
        2'd1:    rom_mem[i] = S1;
        default: rom_mem[i] = S2;
      endcase
    end
    // Sprite 0 texel (dy=2, dx=4) is transparent
    rom_mem[12'h044] = TR;

    step();
    step();
    check_output("reset pixel", pixel, 12'h000);
    check_output("reset cfg_ready", {11'b0, cfg_ready}, 12'h001);
    check_output("reset rom_addr", rom_addr, 12'h000);
    rst = 1'b0;
    step();

    // Idle: background inside the active area, 0 outside
    check_span(10, 0, 20, BG);
    check_span(10, 630, 639, BG);
    check_span(10, 640, 650, 12'h000);
    check_span(479, 0, 3, BG);
    check_span(480, 5, 8, 12'h000);
    row_addr = 9'd51;
    col_addr = 10'd101;
    #1;
    check_output("idle rom_addr", rom_addr, 12'h000);
    step();

    // Sprite 0 at (100,50); no effect until the vs fall
    cfg_write(0, 100, 50, 1'b1);
    check_span(51, 98, 102, BG);
    vs_pulse();
    check_span(51, 96, 99, BG);
    check_span(51, 100, 131, S0);
    check_span(51, 132, 135, BG);
    check_span(49, 110, 110, BG);
    check_span(50, 110, 110, S0);
    check_span(81, 110, 110, S0);
    check_span(82, 110, 110, BG);
    row_addr = 9'd51;
    col_addr = 10'd101;
    #1;
    check_output("rom_addr r51 la103", rom_addr, 12'h023);
    step();

    // Sprite 1 under sprite 0: transparent texel of sprite 0 shows background
    cfg_write(1, 90, 40, 1'b1);
    vs_pulse();
    check_span(52, 88, 89, BG);
    check_span(52, 90, 99, S1);
    check_span(52, 100, 103, S0);
    check_span(52, 104, 104, BG);
    check_span(52, 105, 110, S0);

    // Write held across the commit cycle
    cfg_write(1, 90, 40, 1'b0);
    vs        = 1'b0;
    cfg_valid = 1'b1;
    cfg_idx   = 2'd0;
    cfg_x     = 10'd620;
    cfg_y     = 9'd50;
    cfg_en    = 1'b1;
    #1;
    check_output("cfg_ready in commit", {11'b0, cfg_ready}, 12'h000);
    step();
    check_output("cfg_ready after commit", {11'b0, cfg_ready}, 12'h001);
    vs = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_span(51, 100, 101, S0);
    check_span(52, 95, 95, BG);
    vs_pulse();
    check_span(51, 100, 101, BG);
    check_span(51, 616, 619, BG);
    check_span(51, 620, 639, S0);
    check_span(51, 640, 645, 12'h000);

    // Sprite at the left edge relies on the col_addr 1022/1023 lookahead
    cfg_write(0, 0, 50, 1'b1);
    vs_pulse();
    check_span(51, 0, 31, S0);
    check_span(51, 32, 33, BG);
    check_span(52, 3, 3, S0);
    check_span(52, 4, 4, BG);

    // Reset mid-line
    row_addr = 9'd51;
    col_addr = 10'd8;
    step();
    col_addr = 10'd9;
    step();
    col_addr = 10'd10;
    check_output("pix before reset", pixel, S0);
    rst = 1'b1;
    #1;
    check_output("pix in reset", pixel, 12'h000);
    check_output("cfg_ready in reset", {11'b0, cfg_ready}, 12'h001);
    step();
    rst = 1'b0;
    step();
    check_span(51, 0, 10, BG);
    vs_pulse();
    check_span(51, 0, 10, BG);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
